// File: rtl/ysyx_22050133_axi_burst_master.sv
// AXI4 master with a single outstanding INCR read or write burst of 1..256 beats.
// Narrow beats land on any byte lane; completion is reported as a one-cycle done/err pulse.
module ysyx_22050133_axi_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter logic [ID_W-1:0] ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [7:0]        req_len,
  input  logic [2:0]        req_size,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ID_W-1:0]   aw_id,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic [2:0]        aw_size,
  output logic [1:0]        aw_burst,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ID_W-1:0]   b_id,
  input  logic [1:0]        b_resp,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ID_W-1:0]   ar_id,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ID_W-1:0]   r_id,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] baddr;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic [2:0]        size_q;
  logic              acc_err;

  logic [LB-1:0]     lane;
  logic              is_last;
  logic              size_ok;
  logic              rd_hs;
  logic              w_hs;
  logic              beat_err;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] data_mask;
  logic              unused_ok;

  assign lane     = baddr[LB-1:0];
  assign is_last  = (beat_cnt == len_q);
  assign size_ok  = (req_size <= 3'(LB));
  assign rd_hs    = (state == RDATA) && r_valid && rd_ready;
  assign w_hs     = (state == WDATA) && wd_valid && w_ready;
  assign beat_err = rd_hs && (r_resp[1] || (r_last != is_last));
  assign unused_ok = ^{b_id, r_id, b_resp[0], r_resp[0]};

  // Bytes covered by one beat of the latched size, before lane shifting.
  always_comb begin
    lane_mask = '0;
    data_mask = '0;
    for (int i = 0; i < NB; i++) lane_mask[i] = (i < (1 << size_q));
    for (int i = 0; i < DATA_W; i++) data_mask[i] = lane_mask[i/8];
  end

  assign ar_id    = ID;
  assign ar_addr  = baddr;
  assign ar_len   = len_q;
  assign ar_size  = size_q;
  assign ar_burst = 2'b01;
  assign aw_id    = ID;
  assign aw_addr  = baddr;
  assign aw_len   = len_q;
  assign aw_size  = size_q;
  assign aw_burst = 2'b01;
  assign rd_data  = (r_data >> {lane, 3'b000}) & data_mask;
  assign w_data   = wd_data << {lane, 3'b000};
  assign w_strb   = lane_mask << lane;
  assign w_last   = is_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    aw_valid  = 1'b0;
    rd_valid  = 1'b0;
    r_ready   = 1'b0;
    rd_last   = 1'b0;
    w_valid   = 1'b0;
    wd_ready  = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && size_ok) state_nx = req_we ? WADDR : RADDR;
      end
      RADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nx = RDATA;
      end
      RDATA: begin
        rd_valid = r_valid;
        r_ready  = rd_ready;
        rd_last  = is_last;
        if (rd_hs && is_last) state_nx = IDLE;
      end
      WADDR: begin
        aw_valid = 1'b1;
        if (aw_ready) state_nx = WDATA;
      end
      WDATA: begin
        w_valid  = wd_valid;
        wd_ready = w_ready;
        if (w_hs && is_last) state_nx = WRESP;
      end
      WRESP: begin
        b_ready = 1'b1;
        if (b_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping; an early r_last only flags an error, the beat count decides the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      baddr    <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      acc_err  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && req_valid) begin
        baddr    <= req_addr;
        len_q    <= req_len;
        size_q   <= req_size;
        beat_cnt <= '0;
        acc_err  <= 1'b0;
        if (!size_ok) begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end
      if (rd_hs || w_hs) begin
        baddr    <= baddr + (ADDR_W'(1) << size_q);
        beat_cnt <= beat_cnt + 8'd1;
        acc_err  <= acc_err | beat_err;
        if (rd_hs && is_last) begin
          done <= 1'b1;
          err  <= acc_err | beat_err;
        end
      end
      if (state == WRESP && b_valid) begin
        done <= 1'b1;
        err  <= acc_err | b_resp[1];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_axi_burst_master.sv
// Scoreboard bench for the AXI burst master: a byte-level reference model queues expected
// AR/AW, read beats, write beats and done/err; a monitor pops them as the DUT presents output.
module tb_ysyx_22050133_axi_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [63:0] wd_data = '0;
  logic        rd_valid, rd_ready = 1'b0, rd_last;
  logic [63:0] rd_data;
  logic        done, err;
  logic        aw_valid, aw_ready = 1'b0;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready = 1'b0, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid = 1'b0, b_ready;
  logic [3:0]  b_id = '0;
  logic [1:0]  b_resp = '0;
  logic        ar_valid, ar_ready = 1'b0;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid = 1'b0, r_ready, r_last = 1'b0;
  logic [3:0]  r_id = '0;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = '0;

  ysyx_22050133_axi_burst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} axExp_t;
  typedef struct packed {logic [63:0] data; logic last;} rdExp_t;
  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last;} wExp_t;
  typedef struct packed {logic [63:0] data; logic [1:0] resp; logic last;} rBeat_t;

  axExp_t      expAr[$], expAw[$];
  rdExp_t      expRd[$];
  wExp_t       expW[$];
  logic        expDone[$];
  rBeat_t      slvR[$];
  logic [1:0]  slvB[$];
  logic [63:0] wdQ[$];

  int checks = 0, errors = 0;
  int doneSeen = 0;
  int rCredit = 0, bCredit = 0;
  bit inReset = 1'b1;
  bit inReadData = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] byteMask(input int nbytes);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < nbytes; i++) m[8*i +: 8] = 8'hff;
    return m;
  endfunction

  // Reference model: walk the burst byte-address by byte-address and queue what the bus should show.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input logic [7:0] len,
                               input logic [2:0] size, input int errBeat, input int earlyLast);
    bit          expErr;
    int          nb, lane, strbInt, n;
    logic [31:0] a;
    logic [63:0] d;
    axExp_t      ax;
    rdExp_t      re;
    wExp_t       we_e;
    rBeat_t      rb;
    logic [1:0]  br;
    expErr = 1'b0;
    if (size > 3'd3) begin
      expErr = 1'b1;
    end else begin
      nb = 1 << size;
      ax.addr = addr; ax.len = len; ax.size = size;
      if (we) expAw.push_back(ax); else expAr.push_back(ax);
      for (int k = 0; k <= int'(len); k++) begin
        a = addr + 32'(k * nb);
        lane = int'(a[2:0]);
        d = {$urandom, $urandom};
        if (we) begin
          strbInt = ((1 << nb) - 1) << lane;
          we_e.data = d << (8 * lane);
          we_e.strb = strbInt[7:0];
          we_e.last = (k == int'(len));
          expW.push_back(we_e);
          wdQ.push_back(d);
        end else begin
          rb.data = d;
          rb.resp = (k == errBeat) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
          rb.last = (k == int'(len)) || (k == earlyLast);
          if (rb.resp[1] || (rb.last != (k == int'(len)))) expErr = 1'b1;
          slvR.push_back(rb);
          re.data = (d >> (8 * lane)) & byteMask(nb);
          re.last = (k == int'(len));
          expRd.push_back(re);
        end
      end
      if (we) begin
        br = (errBeat >= 0) ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
        if (br[1]) expErr = 1'b1;
        slvB.push_back(br);
      end
    end
    expDone.push_back(expErr);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_len = len; req_size = size;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk); #3; n++;
    end
    checkOutput("req_accept", {63'd0, req_ready}, 64'd1);
    @(negedge clk); #3;
    req_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (doneSeen < target && n < 3000) begin
      @(negedge clk); #3; n++;
    end
    checkOutput("done_timeout", {63'd0, doneSeen >= target}, 64'd1);
  endtask

  task automatic runTxn(input logic [31:0] addr, input bit we, input logic [7:0] len,
                        input logic [2:0] size, input int errBeat, input int earlyLast);
    int tgt;
    tgt = doneSeen + 1;
    applyStimulus(addr, we, len, size, errBeat, earlyLast);
    waitDone(tgt);
  endtask

  // Slave and request-side data drivers; handshakes are judged #1 after driving, before the edge.
  always @(negedge clk) begin
    if (inReset) begin
      ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; rd_ready = 1'b0;
      r_valid = 1'b0; b_valid = 1'b0; wd_valid = 1'b0;
    end else begin
      ar_ready = 1'($urandom_range(0, 1));
      aw_ready = 1'($urandom_range(0, 1));
      w_ready  = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 3) != 0);
      r_valid  = (rCredit > 0) && (slvR.size() > 0) && ($urandom_range(0, 3) != 0);
      r_data   = (slvR.size() > 0) ? slvR[0].data : {$urandom, $urandom};
      r_resp   = (slvR.size() > 0) ? slvR[0].resp : 2'b00;
      r_last   = (slvR.size() > 0) ? slvR[0].last : 1'b0;
      r_id     = 4'($urandom);
      wd_valid = (wdQ.size() > 0) && ($urandom_range(0, 3) != 0);
      wd_data  = (wdQ.size() > 0) ? wdQ[0] : 64'd0;
      b_valid  = (bCredit > 0) && ($urandom_range(0, 1) != 0);
      b_resp   = (slvB.size() > 0) ? slvB[0] : 2'b00;
      b_id     = 4'($urandom);
      #1;
      if (ar_valid && ar_ready) rCredit = int'(ar_len) + 1;
      if (r_valid && r_ready) begin
        void'(slvR.pop_front());
        rCredit--;
      end
      if (wd_valid && wd_ready) void'(wdQ.pop_front());
      if (w_valid && w_ready && w_last) bCredit = 1;
      if (b_valid && b_ready) begin
        void'(slvB.pop_front());
        bCredit = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a transfer or a completion.
  always @(negedge clk) begin
    axExp_t ax;
    rdExp_t re;
    wExp_t  we_e;
    bit     endRead;
    #2;
    endRead = 1'b0;
    if (!inReset) begin
      if (inReadData) begin
        checkOutput("r_ready_follows_rd_ready", {63'd0, r_ready}, {63'd0, rd_ready});
        checkOutput("rd_valid_follows_r_valid", {63'd0, rd_valid}, {63'd0, r_valid});
      end
      if (ar_valid && ar_ready) begin
        if (expAr.size() == 0) checkOutput("unexpected_ar", {32'd0, ar_addr}, 64'd0);
        else begin
          ax = expAr.pop_front();
          checkOutput("ar_addr", {32'd0, ar_addr}, {32'd0, ax.addr});
          checkOutput("ar_len_size_burst", {51'd0, ar_len, ar_size, ar_burst}, {51'd0, ax.len, ax.size, 2'b01});
        end
      end
      if (aw_valid && aw_ready) begin
        if (expAw.size() == 0) checkOutput("unexpected_aw", {32'd0, aw_addr}, 64'd0);
        else begin
          ax = expAw.pop_front();
          checkOutput("aw_addr", {32'd0, aw_addr}, {32'd0, ax.addr});
          checkOutput("aw_len_size_burst", {51'd0, aw_len, aw_size, aw_burst}, {51'd0, ax.len, ax.size, 2'b01});
        end
      end
      if (rd_valid && rd_ready) begin
        if (expRd.size() == 0) checkOutput("unexpected_rd_beat", rd_data, 64'd0);
        else begin
          re = expRd.pop_front();
          checkOutput("rd_data", rd_data, re.data);
          checkOutput("rd_last", {63'd0, rd_last}, {63'd0, re.last});
          endRead = re.last;
        end
      end
      if (w_valid && w_ready) begin
        if (expW.size() == 0) checkOutput("unexpected_w_beat", w_data, 64'd0);
        else begin
          we_e = expW.pop_front();
          checkOutput("w_data", w_data, we_e.data);
          checkOutput("w_strb_last", {55'd0, w_strb, w_last}, {55'd0, we_e.strb, we_e.last});
        end
      end
      if (done) begin
        if (expDone.size() == 0) checkOutput("unexpected_done", {63'd0, done}, 64'd0);
        else checkOutput("done_err", {63'd0, err}, {63'd0, expDone.pop_front()});
        doneSeen++;
      end else if (err) begin
        checkOutput("err_without_done", {63'd0, err}, 64'd0);
      end
      if (ar_valid && ar_ready) inReadData = 1'b1;
      if (endRead) inReadData = 1'b0;
    end
  end

  initial begin
    int n, len, sz, eb, el;
    rst = 1'b1;
    inReset = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_valids", {58'd0, ar_valid, aw_valid, w_valid, rd_valid, b_ready, wd_ready}, 64'd0);
    checkOutput("reset_done_err", {62'd0, done, err}, 64'd0);
    rst = 1'b0;
    inReset = 1'b0;
    @(negedge clk); #3;
    checkOutput("idle_req_ready", {63'd0, req_ready}, 64'd1);

    $display("[TB] directed transactions");
    runTxn(32'h8000_0000, 1'b0, 8'd3, 3'd3, -1, -1);
    runTxn(32'h8000_0005, 1'b1, 8'd0, 3'd0, -1, -1);
    runTxn(32'h8000_0006, 1'b0, 8'd0, 3'd1, -1, -1);
    runTxn(32'h8000_0010, 1'b1, 8'd1, 3'd2, 0, -1);
    runTxn(32'h8000_0020, 1'b0, 8'd2, 3'd3, -1, 1);
    runTxn(32'h8000_0040, 1'b0, 8'd1, 3'd4, -1, -1);
    runTxn(32'hFFFF_FFF8, 1'b0, 8'd2, 3'd3, -1, -1);
    runTxn(32'h8000_0103, 1'b1, 8'd5, 3'd1, -1, -1);
    runTxn(32'h8000_1000, 1'b1, 8'd255, 3'd0, -1, -1);

    $display("[TB] reset during write data phase");
    applyStimulus(32'h8000_0200, 1'b1, 8'd3, 3'd3, -1, -1);
    n = 0;
    while (expW.size() > 3 && n < 500) begin
      @(negedge clk); #3; n++;
    end
    checkOutput("reached_wdata", {63'd0, expW.size() <= 3}, 64'd1);
    rst = 1'b1;
    inReset = 1'b1;
    expAr.delete(); expAw.delete(); expRd.delete(); expW.delete(); expDone.delete();
    slvR.delete(); slvB.delete(); wdQ.delete();
    rCredit = 0; bCredit = 0; inReadData = 1'b0;
    @(negedge clk); #3;
    checkOutput("abort_valids", {59'd0, ar_valid, aw_valid, w_valid, rd_valid, b_ready}, 64'd0);
    checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("abort_no_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    inReset = 1'b0;
    repeat (5) @(negedge clk);
    #3;

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 7));
      sz  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      eb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      el  = (len > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      runTxn($urandom, 1'($urandom_range(0, 1)), 8'(len), 3'(sz), eb, el);
    end

    repeat (5) @(negedge clk);
    #3;
    checkOutput("scoreboard_drained",
                64'(expAr.size() + expAw.size() + expRd.size() + expW.size() + expDone.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
